xm_pipeline_latch: RTL and testbench
====================================

Name: xm_pipeline_latch

Overview:
Execute-to-Memory pipeline register of the 5-stage processor. It captures the executing instruction, its result, its store data and its 5-bit write-control bundle, and presents them as IR_Memory / O_Memory / B_Memory / wC_Memory to the memory stage and to the execute-stage bypass logic.
It also sequences multicycle mult/div: it launches the multdiv unit, stalls the front of the pipe, and injects bubbles until the result is ready.

Parameters:
MD_TIMEOUT, 40, maximum cycles in BUSY before a forced exception (used only with the optional feature)
RSTATUS_MULT, 4, rstatus code written to r30 on mult exception
RSTATUS_DIV, 5, rstatus code written to r30 on div exception

Ports:
clock  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  squash the current execute instruction; insert a bubble
IR_Execute  input  32  instruction in execute
O_Execute  input  32  ALU / PC+1 result
B_Execute  input  32  store data (bypassed operand B)
wC_Execute  input  5  control bundle: [0] reg write, [1] mem write, [2] mem-to-reg, [3] jal, [4] exception writes r30
A_md, B_md  input  32 each  bypassed mult/div operands (pass-through)
md_result  input  32  multdiv result
md_resultRDY  input  1  multdiv done pulse
md_exception  input  1  multdiv exception, valid with md_resultRDY
ctrl_MULT, ctrl_DIV  output  1 each  one-cycle start pulses to multdiv
md_opA, md_opB  output  32 each  operands to multdiv
stall_md  output  1  freezes PC, F/D and D/X latches
IR_Memory  output  32  latched instruction
O_Memory  output  32  latched result
B_Memory  output  32  latched store data
wC_Memory  output  5  latched control bundle

Behaviour:
- Reset (reset low, asynchronous): IR_Memory, O_Memory and B_Memory = 0; wC_Memory = 0; state = IDLE; ctrl pulses = 0; stall_md = 0.
- md_op decode: IR_Execute[31:27] == 00000 and IR_Execute[6:2] == 00110 (mult) or 00111 (div).
- States: IDLE, BUSY.
- IDLE, no md_op: capture all Execute inputs into the Memory outputs on each rising edge. Latency 1 cycle.
- IDLE with md_op (and no flush):
  - ctrl_MULT or ctrl_DIV = 1 combinationally this cycle.
  - md_opA/B = A_md/B_md.
  - stall_md = 1.
  - Edge: latch a bubble (IR = 0, O = 0, B = 0, wC = 0); state -> BUSY.
- BUSY, md_resultRDY = 0: stall_md = 1; a bubble is latched every edge; ctrl pulses = 0.
- BUSY, md_resultRDY = 1: stall_md = 0 combinationally this cycle. Edge: IR_Memory = IR_Execute; state -> IDLE.
  - md_exception = 0: O_Memory = md_result; wC_Memory = wC_Execute with [4] = 0.
  - md_exception = 1: O_Memory = RSTATUS_MULT or RSTATUS_DIV; wC_Memory = wC_Execute with [4] = 1 and [0] = 1.
- A back-to-back md_op in the next cycle restarts from IDLE normally. No result is lost or duplicated.
- flush (highest priority, any state): bubble latched; state -> IDLE; stall_md = 0; ctrl pulses suppressed. A later md_resultRDY with state IDLE is ignored.
- md_resultRDY in IDLE: ignored.
- B_Memory always tracks B_Execute on a capture, and is 0 on a bubble.
- No arithmetic beyond the timeout counter. All outputs are registered except ctrl_MULT, ctrl_DIV, md_opA/B and stall_md, which are combinational.

Optional Feature:
MD_TIMEOUT_EN
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - At MD_TIMEOUT cycles without md_resultRDY, it behaves as md_resultRDY = 1 with md_exception = 1 (r30 gets the rstatus code) and returns to IDLE.
  - The counter clears on reset and on flush.
- Undefined: no counter; BUSY waits indefinitely.

Test Plan:
- Reset low mid-BUSY -> all Memory outputs 0 and stall_md 0 immediately, without waiting for a clock edge; state IDLE after release.
- add (IR = 0x00A30000 pattern), O_Execute = 0x1234, wC = 00001 -> next edge O_Memory = 0x1234, wC_Memory = 00001, stall_md = 0.
- mult, A_md = 6, B_md = 7, RDY after 32 cycles with result 42 -> ctrl_MULT high exactly 1 cycle; stall_md high 32 cycles; 32 bubbles latched; then O_Memory = 42, wC_Memory[0] = 1, [4] = 0.
- div by 0 with md_exception = 1 -> O_Memory = 5, wC_Memory[4] = 1; next non-md instruction latches normally.
- flush asserted in the 3rd BUSY cycle -> bubble, IDLE, stall_md = 0; a later RDY is ignored and O_Memory does not change.
- With MD_TIMEOUT_EN and MD_TIMEOUT = 40, RDY never arrives -> after 40 BUSY cycles O_Memory = 4 (mult), wC_Memory[4] = 1, state IDLE.

Source files
------------

// File: rtl/xm_pipeline_latch.sv
// Execute-to-Memory pipeline register with multicycle mult/div sequencing.
// Optional MD_TIMEOUT_EN adds a BUSY watchdog that forces an md exception.
module xm_pipeline_latch #(
  parameter int unsigned MD_TIMEOUT   = 40,
  parameter int unsigned RSTATUS_MULT = 4,
  parameter int unsigned RSTATUS_DIV  = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] IR_Execute,
  input  logic [31:0] O_Execute,
  input  logic [31:0] B_Execute,
  input  logic [4:0]  wC_Execute,
  input  logic [31:0] A_md,
  input  logic [31:0] B_md,
  input  logic [31:0] md_result,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        stall_md,
  output logic [31:0] IR_Memory,
  output logic [31:0] O_Memory,
  output logic [31:0] B_Memory,
  output logic [4:0]  wC_Memory
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned WCW  = 5;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state;
  logic   op_div;
  logic   is_rtype;
  logic   is_mult;
  logic   is_div;
  logic   md_op;
  logic   timeout;
  logic   done;
  logic   done_exc;

  // mult/div are R-type (opcode 0) with ALU op 00110 / 00111
  assign is_rtype = (IR_Execute[31:27] == 5'b00000);
  assign is_mult  = is_rtype && (IR_Execute[6:2] == 5'b00110);
  assign is_div   = is_rtype && (IR_Execute[6:2] == 5'b00111);
  assign md_op    = is_mult || is_div;

`ifdef MD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MD_TIMEOUT + 1);

  logic [CNT_W-1:0] md_count;

  assign timeout = (state == BUSY) && (md_count == CNT_W'(MD_TIMEOUT - 1));

  // Cycles spent in BUSY; idle, flush and completion all restart it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      md_count <= '0;
    end else if (flush || (state != BUSY) || done) begin
      md_count <= '0;
    end else begin
      md_count <= md_count + CNT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // A real ready pulse takes precedence over a coincident timeout
  assign done     = (state == BUSY) && (md_resultRDY || timeout);
  assign done_exc = md_resultRDY ? md_exception : 1'b1;

  assign ctrl_MULT = reset && !flush && (state == IDLE) && is_mult;
  assign ctrl_DIV  = reset && !flush && (state == IDLE) && is_div;
  assign md_opA    = A_md;
  assign md_opB    = B_md;
  assign stall_md  = reset && !flush &&
                     (((state == IDLE) && md_op) || ((state == BUSY) && !done));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_div    <= 1'b0;
      IR_Memory <= '0;
      O_Memory  <= '0;
      B_Memory  <= '0;
      wC_Memory <= '0;
    end else if (flush) begin
      state     <= IDLE;
      IR_Memory <= '0;
      O_Memory  <= '0;
      B_Memory  <= '0;
      wC_Memory <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_op) begin
            state     <= BUSY;
            op_div    <= is_div;
            IR_Memory <= '0;
            O_Memory  <= '0;
            B_Memory  <= '0;
            wC_Memory <= '0;
          end else begin
            IR_Memory <= IR_Execute;
            O_Memory  <= O_Execute;
            B_Memory  <= B_Execute;
            wC_Memory <= wC_Execute;
          end
        end
        BUSY: begin
          if (done) begin
            state     <= IDLE;
            IR_Memory <= IR_Execute;
            B_Memory  <= B_Execute;
            if (done_exc) begin
              O_Memory  <= op_div ? XLEN'(RSTATUS_DIV) : XLEN'(RSTATUS_MULT);
              wC_Memory <= {1'b1, wC_Execute[3:1], 1'b1};
            end else begin
              O_Memory  <= md_result;
              wC_Memory <= {1'b0, wC_Execute[WCW-2:0]};
            end
          end else begin
            IR_Memory <= '0;
            O_Memory  <= '0;
            B_Memory  <= '0;
            wC_Memory <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xm_pipeline_latch.sv
// Self-checking bench for xm_pipeline_latch: directed vector table plus
// multi-cycle mult/div, flush, reset and (with MD_TIMEOUT_EN) timeout sequences.
module tb_xm_pipeline_latch;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] IR_Execute, O_Execute, B_Execute;
  logic [4:0]  wC_Execute;
  logic [31:0] A_md, B_md, md_result;
  logic        md_resultRDY, md_exception;
  logic        ctrl_MULT, ctrl_DIV, stall_md;
  logic [31:0] md_opA, md_opB;
  logic [31:0] IR_Memory, O_Memory, B_Memory;
  logic [4:0]  wC_Memory;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] ADD  = 32'h00A3_0000;
  localparam logic [31:0] MULT = 32'h00A3_0018;
  localparam logic [31:0] DIV  = 32'h00A3_001C;

  typedef struct {
    logic [31:0] ir, o, b;
    logic [4:0]  wc;
    logic        fl;
    logic [31:0] eir, eo, eb;
    logic [4:0]  ewc;
  } vec_t;

  vec_t vecs[6];

  xm_pipeline_latch dut (
    .clock(clock), .reset(reset), .flush(flush),
    .IR_Execute(IR_Execute), .O_Execute(O_Execute), .B_Execute(B_Execute),
    .wC_Execute(wC_Execute), .A_md(A_md), .B_md(B_md),
    .md_result(md_result), .md_resultRDY(md_resultRDY), .md_exception(md_exception),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .md_opA(md_opA), .md_opB(md_opB),
    .stall_md(stall_md), .IR_Memory(IR_Memory), .O_Memory(O_Memory),
    .B_Memory(B_Memory), .wC_Memory(wC_Memory)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] b,
                       input logic [4:0] wc);
    IR_Execute = ir; O_Execute = o; B_Execute = b; wC_Execute = wc;
  endtask

  // Hold an md op for n cycles without ready; count stall/ctrl/bubble behaviour
  task automatic busy_run(input int n, output int stall_hi, output int ctrl_hi,
                          output int bad_bubble);
    stall_hi = 0; ctrl_hi = 0; bad_bubble = 0;
    for (int c = 0; c < n; c++) begin
      #1;
      stall_hi += int'(stall_md);
      ctrl_hi  += int'(ctrl_MULT) + int'(ctrl_DIV);
      tick();
      if (IR_Memory !== 32'd0 || O_Memory !== 32'd0 || B_Memory !== 32'd0 ||
          wC_Memory !== 5'd0)
        bad_bubble++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sh, ch, bb;

    vecs[0] = '{ADD,          32'h1234, 32'h00B0, 5'b00001, 1'b0, ADD,          32'h1234, 32'h00B0, 5'b00001};
    vecs[1] = '{32'h40A30000, 32'h0100, 32'h0000, 5'b00101, 1'b0, 32'h40A30000, 32'h0100, 32'h0000, 5'b00101};
    vecs[2] = '{32'h38A30000, 32'h0200, 32'hCAFE, 5'b00010, 1'b0, 32'h38A30000, 32'h0200, 32'hCAFE, 5'b00010};
    vecs[3] = '{32'h28000018, 32'h0033, 32'h0044, 5'b00001, 1'b0, 32'h28000018, 32'h0033, 32'h0044, 5'b00001};
    vecs[4] = '{ADD,          32'h0099, 32'h0001, 5'b00001, 1'b1, 32'h0,        32'h0,    32'h0,    5'b00000};
    vecs[5] = '{32'h18000010, 32'h0007, 32'h0000, 5'b01001, 1'b0, 32'h18000010, 32'h0007, 32'h0000, 5'b01001};

    reset = 1'b0; flush = 1'b0;
    drive(MULT, 32'h5555, 32'h6666, 5'b11111);
    A_md = 32'd6; B_md = 32'd7; md_result = 32'd0; md_resultRDY = 1'b0; md_exception = 1'b0;
    #12;
    chk("reset_ir", IR_Memory, 32'd0);
    chk("reset_o", O_Memory, 32'd0);
    chk("reset_b", B_Memory, 32'd0);
    chk("reset_wc", 32'(wC_Memory), 32'd0);
    chk("reset_stall", 32'(stall_md), 32'd0);
    chk("reset_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    drive(ADD, 32'd0, 32'd0, 5'd0);
    tick();

    // Table of single-cycle captures in IDLE
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].ir, vecs[i].o, vecs[i].b, vecs[i].wc);
      flush = vecs[i].fl;
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(stall_md), 32'd0);
      chk($sformatf("vec%0d_ctrl", i), 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
      tick();
      chk($sformatf("vec%0d_ir", i), IR_Memory, vecs[i].eir);
      chk($sformatf("vec%0d_o", i), O_Memory, vecs[i].eo);
      chk($sformatf("vec%0d_b", i), B_Memory, vecs[i].eb);
      chk($sformatf("vec%0d_wc", i), 32'(wC_Memory), 32'(vecs[i].ewc));
    end
    flush = 1'b0;

    // mult 6*7, ready after 32 stalled cycles
    drive(MULT, 32'hFFFF, 32'h0B0B, 5'b00001);
    A_md = 32'd6; B_md = 32'd7;
    #1;
    chk("mult_opA", md_opA, 32'd6);
    chk("mult_opB", md_opB, 32'd7);
    chk("mult_ctrl_div", 32'(ctrl_DIV), 32'd0);
    busy_run(32, sh, ch, bb);
    chk("mult_stall_cycles", 32'(sh), 32'd32);
    chk("mult_ctrl_cycles", 32'(ch), 32'd1);
    chk("mult_bubbles_bad", 32'(bb), 32'd0);
    md_resultRDY = 1'b1; md_result = 32'd42;
    #1;
    chk("mult_rdy_stall", 32'(stall_md), 32'd0);
    chk("mult_rdy_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    tick();
    md_resultRDY = 1'b0;
    chk("mult_ir", IR_Memory, MULT);
    chk("mult_o", O_Memory, 32'd42);
    chk("mult_b", B_Memory, 32'h0B0B);
    chk("mult_wc", 32'(wC_Memory), 32'b00001);

    // div by zero raising an exception, then a back-to-back mult
    drive(DIV, 32'd0, 32'd0, 5'b00001);
    A_md = 32'd9; B_md = 32'd0;
    #1;
    chk("div_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'b01);
    busy_run(3, sh, ch, bb);
    chk("div_stall_cycles", 32'(sh), 32'd3);
    md_resultRDY = 1'b1; md_exception = 1'b1; md_result = 32'hDEAD;
    tick();
    md_resultRDY = 1'b0; md_exception = 1'b0;
    chk("div_exc_o", O_Memory, 32'd5);
    chk("div_exc_wc", 32'(wC_Memory), 32'b10001);
    drive(MULT, 32'd0, 32'd0, 5'b00001);
    #1;
    chk("b2b_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'b10);
    chk("b2b_stall", 32'(stall_md), 32'd1);
    tick();
    md_resultRDY = 1'b1; md_result = 32'd99;
    tick();
    md_resultRDY = 1'b0;
    chk("b2b_o", O_Memory, 32'd99);
    chk("b2b_wc", 32'(wC_Memory), 32'b00001);
    drive(ADD, 32'h0ABC, 32'h0DEF, 5'b00001);
    tick();
    chk("after_md_o", O_Memory, 32'h0ABC);
    chk("after_md_b", B_Memory, 32'h0DEF);

    // flush in the 3rd BUSY cycle, later ready ignored
    drive(MULT, 32'd0, 32'd0, 5'b00001);
    tick();
    tick();
    tick();
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(stall_md), 32'd0);
    chk("flush_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_ir", IR_Memory, 32'd0);
    chk("flush_wc", 32'(wC_Memory), 32'd0);
    drive(ADD, 32'h0077, 32'h0001, 5'b00001);
    md_resultRDY = 1'b1; md_exception = 1'b1; md_result = 32'hBEEF;
    #1;
    chk("late_rdy_stall", 32'(stall_md), 32'd0);
    tick();
    md_resultRDY = 1'b0; md_exception = 1'b0;
    chk("late_rdy_o", O_Memory, 32'h0077);
    chk("late_rdy_wc", 32'(wC_Memory), 32'b00001);

`ifdef MD_TIMEOUT_EN
    // ready never arrives: forced mult exception on the 40th BUSY cycle
    drive(MULT, 32'd0, 32'd0, 5'b00001);
    tick();
    busy_run(39, sh, ch, bb);
    chk("to_stall_cycles", 32'(sh), 32'd39);
    chk("to_bubbles_bad", 32'(bb), 32'd0);
    #1;
    chk("to_stall_release", 32'(stall_md), 32'd0);
    tick();
    chk("to_o", O_Memory, 32'd4);
    chk("to_wc", 32'(wC_Memory), 32'b10001);
    drive(ADD, 32'h0321, 32'd0, 5'b00001);
    tick();
    chk("to_idle_o", O_Memory, 32'h0321);
`endif

    // asynchronous reset in the middle of BUSY
    drive(MULT, 32'd0, 32'd0, 5'b00001);
    tick();
    tick();
    #1;
    chk("pre_reset_stall", 32'(stall_md), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_stall", 32'(stall_md), 32'd0);
    chk("async_reset_o", O_Memory, 32'd0);
    chk("async_reset_wc", 32'(wC_Memory), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    drive(ADD, 32'h0456, 32'h0789, 5'b00001);
    #1;
    chk("post_reset_stall", 32'(stall_md), 32'd0);
    tick();
    chk("post_reset_o", O_Memory, 32'h0456);
    chk("post_reset_ir", IR_Memory, ADD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
